// File: rtl/semaforo_ctrl.sv
// semaforo_ctrl -- phase sequencer for a turn light (A) and a pedestrian
// light (B), each a semaforo2-style light driven over en/set/change.
//
// Cycle: START (lights load their initial colour from set) -> A_GO -> A_CLR
// -> B_GO -> B_CLR -> A_GO ... A pending pedestrian request shortens A_GO
// to T_MIN_A cycles. The {green,red} feedback of both lights is compared
// with the colour each phase expects, and any disagreement latches FAULT.
// Only reset leaves FAULT.
//
// Handshake: there is no valid/ready pair here. change_a/change_b are
// single-cycle toggle strobes that the lights act on at the next clklf
// edge. en is a level that is high in every running phase.
//
// Ports
//   clklf     in   clock
//   reset     in   synchronous, active-high reset
//   run       in   1 = operate, 0 = shut the lights off
//   ped_req   in   pedestrian request (any-length pulse, latched)
//   green_a   in   light A green feedback
//   red_a     in   light A red feedback
//   green_b   in   light B green feedback
//   red_b     in   light B red feedback
//   en        out  enable to both lights
//   set_a     out  A initial colour select (0 = start green)
//   set_b     out  B initial colour select (1 = start red)
//   change_a  out  one-cycle toggle strobe to light A
//   change_b  out  one-cycle toggle strobe to light B
//   phase     out  current state code (also serves as the FSM debug view)
//   ped_pend  out  latched pedestrian request
//   fault     out  sticky feedback-mismatch flag
module semaforo_ctrl #(
  parameter int CNT_W     = 8,
  parameter int T_GREEN_A = 20,
  parameter int T_MIN_A   = 8,
  parameter int T_GREEN_B = 10,
  parameter int T_CLEAR   = 4,
  parameter int T_START   = 2
) (
  input  logic       clklf,
  input  logic       reset,
  input  logic       run,
  input  logic       ped_req,
  input  logic       green_a,
  input  logic       red_a,
  input  logic       green_b,
  input  logic       red_b,
  output logic       en,
  output logic       set_a,
  output logic       set_b,
  output logic       change_a,
  output logic       change_b,
  output logic [2:0] phase,
  output logic       ped_pend,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_START = 3'd1,
    S_A_GO  = 3'd2,
    S_A_CLR = 3'd3,
    S_B_GO  = 3'd4,
    S_B_CLR = 3'd5,
    S_FAULT = 3'd7
  } state_t;

  // Last elapsed value of each timed phase (elapsed counts from 0).
  localparam logic [CNT_W-1:0] LAST_START   = CNT_W'(T_START - 1);
  localparam logic [CNT_W-1:0] LAST_GREEN_A = CNT_W'(T_GREEN_A - 1);
  localparam logic [CNT_W-1:0] LAST_MIN_A   = CNT_W'(T_MIN_A - 1);
  localparam logic [CNT_W-1:0] LAST_GREEN_B = CNT_W'(T_GREEN_B - 1);
  localparam logic [CNT_W-1:0] LAST_CLEAR   = CNT_W'(T_CLEAR - 1);
  // Feedback is ignored for the first cycles of a phase: the lights take
  // two cycles to show a change, plus one cycle of margin.
  localparam logic [CNT_W-1:0] SETTLE       = CNT_W'(3);
  localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);

  // Feedback encodings {green, red}.
  localparam logic [1:0] FB_GREEN = 2'b10;
  localparam logic [1:0] FB_RED   = 2'b01;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic             en_q, en_d;
  logic             change_a_q, change_a_d;
  logic             change_b_q, change_b_d;
  logic             ped_pend_q, ped_pend_d;
  logic             fault_q, fault_d;

  logic             running;   // START..B_CLR
  logic             checked;   // A_GO..B_CLR, past the settle window
  logic [1:0]       exp_a, exp_b;
  logic             mismatch;
  logic             a_go_done;

  always_ff @(posedge clklf) begin
    if (reset) begin
      state_q    <= S_OFF;
      elapsed_q  <= '0;
      en_q       <= 1'b0;
      change_a_q <= 1'b0;
      change_b_q <= 1'b0;
      ped_pend_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      elapsed_q  <= elapsed_d;
      en_q       <= en_d;
      change_a_q <= change_a_d;
      change_b_q <= change_b_d;
      ped_pend_q <= ped_pend_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    elapsed_d  = '0;
    en_d       = 1'b0;
    change_a_d = 1'b0;
    change_b_d = 1'b0;
    ped_pend_d = ped_pend_q;
    fault_d    = fault_q;
    exp_a      = FB_RED;
    exp_b      = FB_RED;

    running = (state_q == S_START) || (state_q == S_A_GO) ||
              (state_q == S_A_CLR) || (state_q == S_B_GO) ||
              (state_q == S_B_CLR);
    checked = running && (state_q != S_START) && (elapsed_q >= SETTLE);

    if (state_q == S_A_GO) exp_a = FB_GREEN;
    if (state_q == S_B_GO) exp_b = FB_GREEN;
    // 11 and 00 both differ from either legal encoding, so they are caught.
    mismatch = checked && (({green_a, red_a} != exp_a) ||
                           ({green_b, red_b} != exp_b));

    // Nominal end of green, or an early end once a request is pending and
    // the minimum green has been served. Both cases take the same exit.
    a_go_done = (elapsed_q == LAST_GREEN_A) ||
                (ped_pend_q && (elapsed_q >= LAST_MIN_A));

    if (mismatch) begin
      state_d = S_FAULT;
    end else if (running && !run) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF:   if (run) state_d = S_START;
        S_START: if (elapsed_q == LAST_START) state_d = S_A_GO;
        S_A_GO:  if (a_go_done) state_d = S_A_CLR;
        S_A_CLR: if (elapsed_q == LAST_CLEAR) state_d = S_B_GO;
        S_B_GO:  if (elapsed_q == LAST_GREEN_B) state_d = S_B_CLR;
        S_B_CLR: if (elapsed_q == LAST_CLEAR) state_d = S_A_GO;
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_OFF;
      endcase
    end

    // elapsed restarts at every entry and only advances in timed phases.
    if ((state_d == state_q) && running) elapsed_d = elapsed_q + ONE;

    en_d = (state_d == S_START) || (state_d == S_A_GO) ||
           (state_d == S_A_CLR) || (state_d == S_B_GO) ||
           (state_d == S_B_CLR);

    // Toggle strobes accompany only the phase-to-phase transitions; the
    // START -> A_GO step needs none because the lights loaded from set.
    change_a_d = ((state_q == S_A_GO)  && (state_d == S_A_CLR)) ||
                 ((state_q == S_B_CLR) && (state_d == S_A_GO));
    change_b_d = ((state_q == S_A_CLR) && (state_d == S_B_GO)) ||
                 ((state_q == S_B_GO)  && (state_d == S_B_CLR));

    // Entry into walk serves the request; requests during walk are dropped.
    if ((state_d == S_B_GO) && (state_q != S_B_GO)) begin
      ped_pend_d = 1'b0;
    end else if (ped_req && (state_q != S_B_GO) && (state_q != S_FAULT)) begin
      ped_pend_d = 1'b1;
    end

    if (state_d == S_FAULT) fault_d = 1'b1;
  end

  assign en       = en_q;
  assign set_a    = 1'b0;
  assign set_b    = 1'b1;
  assign change_a = change_a_q;
  assign change_b = change_b_q;
  assign phase    = state_q;
  assign ped_pend = ped_pend_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Testbench for semaforo_ctrl. The expected behaviour is a per-cycle
// timeline assembled from phase durations (START, A_GO, A_CLR, B_GO, B_CLR)
// and request placements. The observation vector compared each cycle is
// {phase[2:0], en, change_a, change_b, ped_pend, fault}.
module tb_semaforo_ctrl;

  localparam int T_GREEN_A = 20;
  localparam int T_MIN_A   = 8;
  localparam int T_GREEN_B = 10;
  localparam int T_CLEAR   = 4;
  localparam int T_START   = 2;
  localparam int NONE      = 1000;

  logic       clklf = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       ped_req = 1'b0;
  logic       green_a, red_a, green_b, red_b;
  logic       en, set_a, set_b, change_a, change_b, ped_pend, fault;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       req_q[$];
  logic [7:0] obs;

  // clock / reset block
  always #5 clklf = ~clklf;

  semaforo_ctrl dut (
    .clklf    (clklf),
    .reset    (reset),
    .run      (run),
    .ped_req  (ped_req),
    .green_a  (green_a),
    .red_a    (red_a),
    .green_b  (green_b),
    .red_b    (red_b),
    .en       (en),
    .set_a    (set_a),
    .set_b    (set_b),
    .change_a (change_a),
    .change_b (change_b),
    .phase    (phase),
    .ped_pend (ped_pend),
    .fault    (fault)
  );

  // Light model: colour register (0 = green, 1 = red) loaded from set while
  // disabled, toggled by change; feedback appears light_lat cycles after the
  // change strobe. Dark (00) while disabled.
  int         light_lat = 2;
  logic       force_gg = 1'b0;
  logic       col_a = 1'b0, col_b = 1'b1;
  logic [1:0] p1_a = 2'b00, p2_a = 2'b00, p1_b = 2'b00, p2_b = 2'b00;
  logic [1:0] fb_a, fb_b;

  always @(posedge clklf) begin
    if (!en) begin
      col_a <= set_a;
      col_b <= set_b;
    end else begin
      if (change_a) col_a <= ~col_a;
      if (change_b) col_b <= ~col_b;
    end
    p1_a <= en ? (col_a ? 2'b01 : 2'b10) : 2'b00;
    p1_b <= en ? (col_b ? 2'b01 : 2'b10) : 2'b00;
    p2_a <= p1_a;
    p2_b <= p1_b;
  end

  assign fb_a    = (light_lat == 2) ? p1_a : p2_a;
  assign fb_b    = (light_lat == 2) ? p1_b : p2_b;
  assign green_a = fb_a[1] | force_gg;
  assign red_a   = fb_a[0];
  assign green_b = fb_b[1] | force_gg;
  assign red_b   = fb_b[0];

  // driver tasks
  task automatic do_reset();
    reset    = 1'b1;
    run      = 1'b0;
    ped_req  = 1'b0;
    force_gg = 1'b0;
    repeat (2) @(posedge clklf);
    #1;
    reset = 1'b0;
  endtask

  // Append len cycles of one phase to the expected timeline. ca/cb mark a
  // toggle strobe in the first cycle; ped_pend is expected from elapsed
  // index pend_from onward (NONE = never).
  task automatic push_phase(input logic [2:0] ph, input int len, input logic ca,
                            input logic cb, input int pend_from);
    for (int e = 0; e < len; e++) begin
      exp_q.push_back({ph, 1'b1, ca && (e == 0), cb && (e == 0),
                       (e >= pend_from), 1'b0});
      req_q.push_back(1'b0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    obs = {phase, en, change_a, change_b, ped_pend, fault};
    checks++;
    if (obs !== 8'b000_0_0_0_0_0) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", obs, 8'b000_0_0_0_0_0);
    end
    checks++;
    if ({set_a, set_b} !== 2'b01) begin
      errors++;
      $display("FAIL set_consts: got %b expected 01", {set_a, set_b});
    end
    // OFF holds with run=0; a request in OFF is latched.
    ped_req = 1'b1;
    @(posedge clklf); #1;
    ped_req = 1'b0;
    repeat (2) @(posedge clklf);
    #1;
    obs = {phase, en, change_a, change_b, ped_pend, fault};
    checks++;
    if (obs !== 8'b000_0_0_0_1_0) begin
      errors++;
      $display("FAIL off_ped_latch: got %b expected %b", obs, 8'b000_0_0_0_1_0);
    end
    do_reset();
    checks++;
    if (ped_pend !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_pend: got %b expected 0", ped_pend);
    end
  endtask

  // Two full cycles with no requests, once with 2-cycle and once with
  // 3-cycle light latency.
  task automatic test_normal_cycle();
    for (int lat = 2; lat <= 3; lat++) begin
      do_reset();
      light_lat = lat;
      exp_q.delete();
      req_q.delete();
      push_phase(3'd1, T_START, 1'b0, 1'b0, NONE);
      for (int r = 0; r < 2; r++) begin
        push_phase(3'd2, T_GREEN_A, (r > 0), 1'b0, NONE);
        push_phase(3'd3, T_CLEAR,   1'b1,    1'b0, NONE);
        push_phase(3'd4, T_GREEN_B, 1'b0,    1'b1, NONE);
        push_phase(3'd5, T_CLEAR,   1'b0,    1'b1, NONE);
      end
      run = 1'b1;
      for (int i = 0; i < exp_q.size(); i++) begin
        @(posedge clklf); #1;
        obs = {phase, en, change_a, change_b, ped_pend, fault};
        checks++;
        if (obs !== exp_q[i]) begin
          errors++;
          $display("FAIL normal_lat%0d cycle %0d: got %b expected %b",
                   lat, i, obs, exp_q[i]);
        end
        ped_req = req_q[i];
      end
      run = 1'b0;
      ped_req = 1'b0;
    end
  endtask

  // Rounds of A_GO/A_CLR/B_GO/B_CLR with one pedestrian request placed per
  // round. Modes: 0 none, 1 in A_GO at elapsed arg, 2 in B_GO (dropped),
  // 3 in A_CLR (served by the B_GO that follows), 4 in B_CLR (shortens the
  // next A_GO to T_MIN_A).
  task automatic test_ped_requests();
    int dir_mode[7] = '{1, 1, 2, 0, 4, 0, 3};
    int dir_arg[7]  = '{2, 15, 5, 0, 2, 0, 1};
    int mode, arg, ago_len, pf_ago, pf_aclr, pf_bclr, base;
    logic carry;
    do_reset();
    light_lat = 2;
    exp_q.delete();
    req_q.delete();
    carry = 1'b0;
    push_phase(3'd1, T_START, 1'b0, 1'b0, NONE);
    for (int r = 0; r < 13; r++) begin
      if (r < 7) begin
        mode = dir_mode[r];
        arg  = dir_arg[r];
      end else begin
        mode = $urandom_range(0, 4);
        arg  = (mode == 1) ? $urandom_range(0, T_GREEN_A - 1) :
               (mode == 2) ? $urandom_range(0, T_GREEN_B - 1) :
                             $urandom_range(0, T_CLEAR - 1);
      end
      if (carry) mode = 0;
      ago_len = T_GREEN_A;
      pf_ago  = NONE;
      pf_aclr = NONE;
      pf_bclr = NONE;
      if (carry) begin
        ago_len = T_MIN_A;
        pf_ago  = 0;
        pf_aclr = 0;
      end else if (mode == 1) begin
        // Pending from the cycle after the request; exit once the minimum
        // is served, never later than the nominal length.
        ago_len = (arg + 2 > T_MIN_A) ? arg + 2 : T_MIN_A;
        if (ago_len > T_GREEN_A) ago_len = T_GREEN_A;
        pf_ago  = arg + 1;
        pf_aclr = 0;
      end else if (mode == 3) begin
        pf_aclr = arg + 1;
      end else if (mode == 4) begin
        pf_bclr = arg + 1;
      end
      base = exp_q.size();
      push_phase(3'd2, ago_len, (r > 0), 1'b0, pf_ago);
      if (mode == 1) req_q[base + arg] = 1'b1;
      base = exp_q.size();
      push_phase(3'd3, T_CLEAR, 1'b1, 1'b0, pf_aclr);
      if (mode == 3) req_q[base + arg] = 1'b1;
      base = exp_q.size();
      push_phase(3'd4, T_GREEN_B, 1'b0, 1'b1, NONE);
      if (mode == 2) req_q[base + arg] = 1'b1;
      base = exp_q.size();
      push_phase(3'd5, T_CLEAR, 1'b0, 1'b1, pf_bclr);
      if (mode == 4) req_q[base + arg] = 1'b1;
      carry = (mode == 4);
    end
    run = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clklf); #1;
      obs = {phase, en, change_a, change_b, ped_pend, fault};
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL ped_cycle %0d: got %b expected %b", i, obs, exp_q[i]);
      end
      ped_req = req_q[i];
    end
    run = 1'b0;
    ped_req = 1'b0;
  endtask

  task automatic test_fault();
    int bgo5;
    do_reset();
    light_lat = 2;
    bgo5 = T_START + T_GREEN_A + T_CLEAR + 5;
    run = 1'b1;
    for (int i = 0; i <= bgo5; i++) begin
      @(posedge clklf); #1;
    end
    checks++;
    if (phase !== 3'd4) begin
      errors++;
      $display("FAIL fault_setup_phase: got %0d expected 4", phase);
    end
    force_gg = 1'b1;
    @(posedge clklf); #1;
    force_gg = 1'b0;
    obs = {phase, en, change_a, change_b, ped_pend, fault};
    checks++;
    if (obs !== 8'b111_0_0_0_0_1) begin
      errors++;
      $display("FAIL fault_entry: got %b expected %b", obs, 8'b111_0_0_0_0_1);
    end
    for (int i = 0; i < 8; i++) begin
      run     = 1'($urandom_range(0, 1));
      ped_req = 1'($urandom_range(0, 1));
      @(posedge clklf); #1;
      obs = {phase, en, change_a, change_b, ped_pend, fault};
      checks++;
      if (obs !== 8'b111_0_0_0_0_1) begin
        errors++;
        $display("FAIL fault_hold %0d: got %b expected %b", i, obs, 8'b111_0_0_0_0_1);
      end
    end
    ped_req = 1'b0;
    run = 1'b1;
    reset = 1'b1;
    @(posedge clklf); #1;
    reset = 1'b0;
    run = 1'b0;
    obs = {phase, en, change_a, change_b, ped_pend, fault};
    checks++;
    if (obs !== 8'b000_0_0_0_0_0) begin
      errors++;
      $display("FAIL fault_reset: got %b expected %b", obs, 8'b000_0_0_0_0_0);
    end
  endtask

  task automatic test_stop_restart();
    logic [7:0] want[3];
    int tgt;
    do_reset();
    light_lat = 2;
    tgt = T_START + T_GREEN_A + $urandom_range(0, T_CLEAR - 1);
    run = 1'b1;
    for (int i = 0; i <= tgt; i++) begin
      @(posedge clklf); #1;
    end
    checks++;
    if (phase !== 3'd3) begin
      errors++;
      $display("FAIL stop_setup_phase: got %0d expected 3", phase);
    end
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clklf); #1;
      obs = {phase, en, change_a, change_b, ped_pend, fault};
      checks++;
      if (obs !== 8'b000_0_0_0_0_0) begin
        errors++;
        $display("FAIL stop_off %0d: got %b expected %b", i, obs, 8'b000_0_0_0_0_0);
      end
    end
    want = '{8'b001_1_0_0_0_0, 8'b001_1_0_0_0_0, 8'b010_1_0_0_0_0};
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clklf); #1;
      obs = {phase, en, change_a, change_b, ped_pend, fault};
      checks++;
      if (obs !== want[i]) begin
        errors++;
        $display("FAIL restart %0d: got %b expected %b", i, obs, want[i]);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_reset_mid();
    int tgt;
    // Request at A_GO elapsed 1 -> A_GO lasts T_MIN_A; reset in A_CLR
    // while the request is still pending.
    do_reset();
    light_lat = 2;
    tgt = T_START + T_MIN_A + 1;
    run = 1'b1;
    for (int i = 0; i <= tgt; i++) begin
      @(posedge clklf); #1;
      ped_req = (i == T_START + 1);
    end
    obs = {phase, en, change_a, change_b, ped_pend, fault};
    checks++;
    if (obs !== 8'b011_1_0_0_1_0) begin
      errors++;
      $display("FAIL mid_aclr_pending: got %b expected %b", obs, 8'b011_1_0_0_1_0);
    end
    reset = 1'b1;
    @(posedge clklf); #1;
    reset = 1'b0;
    obs = {phase, en, change_a, change_b, ped_pend, fault};
    checks++;
    if (obs !== 8'b000_0_0_0_0_0) begin
      errors++;
      $display("FAIL mid_reset_aclr: got %b expected %b", obs, 8'b000_0_0_0_0_0);
    end
    // Reset during B_GO with run held high.
    do_reset();
    tgt = T_START + T_GREEN_A + T_CLEAR + $urandom_range(0, T_GREEN_B - 1);
    run = 1'b1;
    for (int i = 0; i <= tgt; i++) begin
      @(posedge clklf); #1;
    end
    checks++;
    if (phase !== 3'd4) begin
      errors++;
      $display("FAIL mid_bgo_phase: got %0d expected 4", phase);
    end
    reset = 1'b1;
    @(posedge clklf); #1;
    reset = 1'b0;
    run = 1'b0;
    obs = {phase, en, change_a, change_b, ped_pend, fault};
    checks++;
    if (obs !== 8'b000_0_0_0_0_0) begin
      errors++;
      $display("FAIL mid_reset_bgo: got %b expected %b", obs, 8'b000_0_0_0_0_0);
    end
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_ped_requests();
    test_fault();
    test_stop_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
